alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 4-bit ALU between two requester ports.
- Each requester issues {a, b, op} with a valid/ready handshake.
- The arbiter grants one port, drives the latched operands to the ALU, and captures the result.
- It returns the result on that port's response channel; the ALU and 7-seg path stay unchanged downstream.

Parameters:
- DW, 4, operand/result width.
- OPW, 3, op-code width (000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 reserved, 111 eq).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a  in  DW  port 0 operand A.
- req0_b  in  DW  port 0 operand B.
- req0_op  in  OPW  port 0 op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as port 0, for port 1.
- rsp0_valid  out  1  port 0 result valid.
- rsp0_ready  in  1  port 0 result consumed.
- rsp0_data  out  DW  port 0 result.
- rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for port 1.
- alu_a  out  DW  operand A to ALU.
- alu_b  out  DW  operand B to ALU.
- alu_op  out  OPW  op to ALU.
- alu_res  in  DW  combinational ALU result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, any state) clears the following, and all ports are inert until rst deasserts:
  - state = IDLE, priority pointer = 0 (port 0 preferred), owner = 0.
  - all *_ready and rsp*_valid = 0, busy = 0.
  - alu_a/alu_b/alu_op = 0, rsp*_data = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If neither valid: stay.
  - If exactly one valid: grant it.
  - If both valid: grant the port named by the priority pointer.
  - Grant asserts reqN_ready combinationally for the granted port only (ready = IDLE && grantN). Never both readys high.
  - On the grant edge: latch a/b/op into operand registers, record owner, go to ISSUE.
- ISSUE (1 cycle):
  - alu_a/alu_b/alu_op present the latched registers (these outputs always reflect the registers).
  - At the end of the cycle, capture alu_res into the result register; go to RESP.
- RESP:
  - rsp<owner>_valid = 1, rsp<owner>_data = result register. Both hold stable until rsp<owner>_ready = 1.
  - Handshake edge: valid drops, pointer set to the other port, go to IDLE.
  - rsp_ready of the non-owner is ignored. The other port's rsp_valid stays 0.
- Latency: request accepted at edge T → rsp_valid high in cycle T+2. If rsp_ready is already high, handshake at edge T+2, next grant possible at edge T+3. Peak throughput is 1 op / 3 cycles.
- Fairness:
  - The round-robin pointer toggles only on completed response handshakes.
  - With both ports continuously valid, grants alternate 0,1,0,1...
- Requester may drop valid before grant; no requirement on stability while not granted.
- Arithmetic is performed by the ALU; the arbiter passes op codes (including reserved 110) unmodified and stores DW-bit results without extension.
- No new request is accepted in ISSUE or RESP, even if rsp_ready is held low indefinitely.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins simultaneous requests; the pointer is removed/held at 0. Port 1 is granted only when req0_valid is low in IDLE.
- Undefined: round-robin as described above.

Test Plan:
- Bench connects a behavioural 4-bit ALU model using the op encoding above.
- Single op: after reset, req0 {a=3, b=5, op=000} at edge T → req0_ready high in cycle T, rsp0_valid high in cycle T+2, rsp0_data=8. With rsp0_ready=1, busy low at T+3.
- Wrap/sub: req1 {a=2, b=5, op=001} → rsp1_data=4'hD. Then {a=4'hF, b=1, op=000} → 4'h0. Then {a=6, b=6, op=111} → 4'h1.
- Contention: both valid every cycle from reset, distinct ops → grants alternate port 0, port 1, port 0, port 1. Each response is routed only to its owner with correct data. With ALU_ARB_FIXED_PRIO_EN defined → port 0 granted every time, port 1 never.
- Backpressure: rsp0_ready held 0 for 5 cycles in RESP → rsp0_valid and rsp0_data stable, req1_ready stays 0 although req1_valid=1. Release → handshake, req1 granted next cycle.
- Reset mid-op: assert rst during ISSUE → same cycle, busy=0, rsp*_valid=0, alu_* = 0. After release, req0 and req1 both valid → port 0 granted first (pointer reset).

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing one combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module alu_arbiter #(
  parameter int DW  = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [DW-1:0]  rsp0_data,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp1_data,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_res,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           owner;
  logic           ptr;
  logic           grant0;
  logic           grant1;
  logic           rsp_done;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  res_q;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    rsp_done  = 1'b0;
    unique case (state)
      IDLE: begin
        grant0 = req0_valid && (!req1_valid || !ptr);
        grant1 = req1_valid && !grant0;
        if (grant0 || grant1)
          state_nxt = ISSUE;
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        rsp_done = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        owner <= grant1;
        a_q   <= grant1 ? req1_a  : req0_a;
        b_q   <= grant1 ? req1_b  : req0_b;
        op_q  <= grant1 ? req1_op : req0_op;
      end
      if (state == ISSUE)
        res_q <= alu_res;
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = 1'b0;
`else
  // Pointer moves only on completed response handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b0;
    else if (rsp_done)
      ptr <= ~owner;
  end
`endif

  // Readies are combinational, so gate them while reset is held.
  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp0_data  = rsp0_valid ? res_q : '0;
  assign rsp1_data  = rsp1_valid ? res_q : '0;

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and
// per-port response scoreboards.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [3:0] rsp0_data, rsp1_data;
  logic [3:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .busy(busy)
  );

  function automatic logic [3:0] alu_f(
    input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return ~a;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      3'b111:  return (a == b) ? 4'h1 : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int p);
    p = -1;
    for (int i = 0; i < 8 && p < 0; i++) begin
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        chk("both_ready", {31'd0, req0_ready & req1_ready}, 0);
        p = (req1_ready === 1'b1) ? 1 : 0;
      end else begin
        step();
      end
    end
    chk("grant_timeout", {31'd0, p >= 0}, 1);
  endtask

  task automatic wait_rsp(input int p);
    bit got = 0;
    logic [3:0] exp;
    for (int i = 0; i < 8 && !got; i++) begin
      if ((p == 0 ? rsp0_valid : rsp1_valid) === 1'b1) got = 1;
      else step();
    end
    chk("rsp_timeout", {31'd0, got}, 1);
    if (got) begin
      exp = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk("rsp_data", p == 0 ? rsp0_data : rsp1_data, exp);
      chk("rsp_other", p == 0 ? rsp1_valid : rsp0_valid, 0);
    end
    step();
  endtask

  task automatic do_req(input int p, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] exp);
    int g;
    if (p == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
    end
    #1;
    wait_grant(g);
    chk("grant_port", g, p);
    if (p == 0) q0.push_back(exp); else q1.push_back(exp);
    step();
    req0_valid = 0;
    req1_valid = 0;
    wait_rsp(p);
  endtask

  initial begin
    int g;
    int expg;
    logic [3:0] e;
    rst = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_rsp0v", rsp0_valid, 0);
    chk("rst_rsp1v", rsp1_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp0d", rsp0_data, 0);
    step();
    rst = 0;

    // single op latency
    req0_valid = 1; req0_a = 3; req0_b = 5; req0_op = 3'b000;
    #1;
    chk("t_ready0", req0_ready, 1);
    chk("t_ready1", req1_ready, 0);
    q0.push_back(4'd8);
    step();
    req0_valid = 0;
    chk("t1_busy", busy, 1);
    chk("t1_rsp0v", rsp0_valid, 0);
    chk("t1_alu_a", alu_a, 3);
    chk("t1_alu_b", alu_b, 5);
    step();
    chk("t2_rsp0v", rsp0_valid, 1);
    chk("t2_data", rsp0_data, q0.pop_front());
    chk("t2_rsp1v", rsp1_valid, 0);
    step();
    chk("t3_busy", busy, 0);

    do_req(1, 4'h2, 4'h5, 3'b001, 4'hD);
    do_req(1, 4'hF, 4'h1, 3'b000, 4'h0);
    do_req(1, 4'h6, 4'h6, 3'b111, 4'h1);
    do_req(0, 4'h9, 4'h3, 3'b110, 4'h0);

    // contention from reset
    rst = 1;
    req0_valid = 1; req0_a = 4'h1; req0_b = 4'h2; req0_op = 3'b000;
    req1_valid = 1; req1_a = 4'hC; req1_b = 4'hA; req1_op = 3'b101;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    step();
    rst = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      expg = 0;
`else
      expg = k % 2;
`endif
      wait_grant(g);
      chk("cont_grant", g, expg);
      if (g == 1) begin
        q1.push_back(alu_f(req1_a, req1_b, req1_op));
      end else begin
        q0.push_back(alu_f(req0_a, req0_b, req0_op));
      end
      step();
      if (g == 1) begin
        req1_a = req1_a + 4'd3; req1_op = 3'b011;
      end else begin
        req0_a = req0_a + 4'd5; req0_op = 3'b001;
      end
      wait_rsp(g == 1 ? 1 : 0);
    end
    req0_valid = 0; req1_valid = 0;
    step();

    // backpressure
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 4'h7; req0_b = 4'h5; req0_op = 3'b100;
    #1;
    chk("bp_grant0", req0_ready, 1);
    step();
    req0_valid = 0;
    req1_valid = 1; req1_a = 4'hA; req1_b = 4'h3; req1_op = 3'b011;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp0v", rsp0_valid, 1);
      chk("bp_rsp0d", rsp0_data, 4'h7);
      chk("bp_ready1", req1_ready, 0);
      step();
    end
    rsp0_ready = 1;
    step();
    chk("bp_rel_ready1", req1_ready, 1);
    q1.push_back(4'h2);
    step();
    req1_valid = 0;
    wait_rsp(1);

    // reset during ISSUE with pointer pointing at port 1
    do_req(0, 4'h4, 4'h4, 3'b011, 4'h4);
    req0_valid = 1; req0_a = 4'h5; req0_b = 4'h1; req0_op = 3'b000;
    #1;
    chk("mid_grant0", req0_ready, 1);
    step();
    req0_valid = 0;
    rst = 1;
    req1_valid = 1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rsp0v", rsp0_valid, 0);
    chk("mid_rsp1v", rsp1_valid, 0);
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_b", alu_b, 0);
    chk("mid_alu_op", alu_op, 0);
    chk("mid_ready1", req1_ready, 0);
    step();
    rst = 0;
    req0_valid = 1; req0_a = 4'h8; req0_b = 4'h8; req0_op = 3'b111;
    #1;
    chk("post_ready0", req0_ready, 1);
    chk("post_ready1", req1_ready, 0);
    q0.push_back(4'h1);
    step();
    req0_valid = 0; req1_valid = 0;
    wait_rsp(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
